// File: rtl/alu_serial_engine.sv
// Bit-serial-by-slice 74181 ALU: one 4-bit slice per enabled clock, ripple carry held in a register.
// Optional accumulator mode (use_acc port) is compiled in by defining ALU_SERIAL_ENGINE_ACCUM_EN.
module alu_serial_engine #(
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    ena,
    input  logic                    start,
`ifdef ALU_SERIAL_ENGINE_ACCUM_EN
    input  logic                    use_acc,
`endif
    input  logic [4*NUM_SLICES-1:0] a,
    input  logic [4*NUM_SLICES-1:0] b,
    input  logic [3:0]              s,
    input  logic                    m,
    input  logic                    cn,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_SLICES-1:0] f,
    output logic                    cout,
    output logic                    equal,
    output logic                    zero
);

    localparam int unsigned W     = 4 * NUM_SLICES;
    localparam int unsigned IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic               carry, carry_d;
    logic [W-1:0]       a_r, a_d;
    logic [W-1:0]       b_r, b_d;
    logic [3:0]         s_r, s_d;
    logic               m_r, m_d;
    logic [W-1:0]       f_d;
    logic               cout_d, equal_d, zero_d, busy_d, done_d;

    logic [W-1:0]       cap_a_c;
    logic [3:0]         sa_c, sb_c, su_c, sv_c, sf_c;
    logic [4:0]         sum_c;
    logic               scn4_c;

`ifdef ALU_SERIAL_ENGINE_ACCUM_EN
    assign cap_a_c = use_acc ? f : a;
`else
    assign cap_a_c = a;
`endif

    // One 74181 slice: u/v are the complemented first-level gate outputs; arithmetic is u+v+carry,
    // logic is xnor(u,v). Carry-out is produced in both modes, as on the real part.
    always_comb begin
        sa_c   = a_r[int'(idx)*4 +: 4];
        sb_c   = b_r[int'(idx)*4 +: 4];
        su_c   = sa_c | (sb_c & {4{s_r[0]}}) | (~sb_c & {4{s_r[1]}});
        sv_c   = (sa_c & ~sb_c & {4{s_r[2]}}) | (sa_c & sb_c & {4{s_r[3]}});
        sum_c  = {1'b0, su_c} + {1'b0, sv_c} + {4'b0000, ~carry};
        sf_c   = m_r ? ~(su_c ^ sv_c) : sum_c[3:0];
        scn4_c = ~sum_c[4];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        carry_d = carry;
        a_d     = a_r;
        b_d     = b_r;
        s_d     = s_r;
        m_d     = m_r;
        f_d     = f;
        cout_d  = cout;
        equal_d = equal;
        zero_d  = zero;
        busy_d  = busy;
        done_d  = done;
        if (ena) begin
            case (state)
                IDLE: begin
                    busy_d = 1'b0;
                    done_d = 1'b0;
                    if (start) begin
                        a_d     = cap_a_c;
                        b_d     = b;
                        s_d     = s;
                        m_d     = m;
                        carry_d = cn;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    f_d[int'(idx)*4 +: 4] = sf_c;
                    carry_d = scn4_c;
                    idx_d   = idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_SLICES - 1)) begin
                        idx_d   = '0;
                        cout_d  = scn4_c;
                        equal_d = &f_d;
                        zero_d  = ~|f_d;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            s_r   <= '0;
            m_r   <= 1'b0;
            f     <= '0;
            cout  <= 1'b0;
            equal <= 1'b0;
            zero  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            carry <= carry_d;
            a_r   <= a_d;
            b_r   <= b_d;
            s_r   <= s_d;
            m_r   <= m_d;
            f     <= f_d;
            cout  <= cout_d;
            equal <= equal_d;
            zero  <= zero_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule
